// File: rtl/seqdet_pkg.sv
// Shared constants and config type for the serial pattern detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seqdet_pkg;

    localparam int         DEF_PAT_W   = 8;
    localparam int         DEF_CNT_W   = 16;
    localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
    localparam int         DEF_LEN     = 4;

    // Config is held at the widest supported size so one type serves every PAT_W.
    localparam int CFG_PAT_MAX = 32;
    localparam int CFG_LEN_W   = 6;

    typedef struct packed {
        logic [CFG_PAT_MAX-1:0] pattern;
        logic [CFG_LEN_W-1:0]   len;
        logic                   overlap;
    } seqdet_cfg_t;

    // Mask selecting the low 'len' bits of a right-aligned pattern.
    function automatic logic [CFG_PAT_MAX-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
        logic [CFG_PAT_MAX-1:0] m;
        for (int i = 0; i < CFG_PAT_MAX; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/seqdet_match_cnt.sv
// Saturating match counter: counts detector pulses, holds at all-ones.
// Latency: count reflects an increment one clock after inc is seen.
// Backpressure: none; inc is sampled every clock.
module seqdet_match_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment on each match, stop at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern/length/overlap; optional match counter (SEQDET_MATCH_CNT_EN).
// Latency: detector_out pulses one clock after the edge accepting the final pattern bit.
// Backpressure: none; bits are taken only when in_valid=1, cfg_load wins over data.
module seq_detector_param #(
    parameter int               PAT_W       = seqdet_pkg::DEF_PAT_W,
    parameter int               CNT_W       = seqdet_pkg::DEF_CNT_W,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(seqdet_pkg::DEF_PATTERN),
    parameter int               DEF_LEN     = seqdet_pkg::DEF_LEN,
    localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             detector_out
`ifdef SEQDET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    import seqdet_pkg::*;

    localparam seqdet_cfg_t CFG_RESET = '{
        pattern: CFG_PAT_MAX'(DEF_PATTERN),
        len:     CFG_LEN_W'(DEF_LEN),
        overlap: 1'b1
    };

    logic [1:0]       rst_pipe;
    logic             rst_n;
    seqdet_cfg_t      cfg_q, cfg_d;
    logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
    logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
    logic             det_q, det_d;
    logic             len_ok, hit;

    // Assert asynchronously, release two clocks later so state never sees a raw deassert.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    // Next-state: config load has priority and drops the same-edge data bit; otherwise shift and compare.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], sequence_in};
        fill_inc   = (int'(fill_q) >= PAT_W) ? fill_q : fill_q + LEN_W'(1);
        len_ok     = (cfg_q.len != '0) && (int'(cfg_q.len) <= PAT_W);
        hit        = len_ok && (int'(fill_inc) >= int'(cfg_q.len)) &&
                     (((CFG_PAT_MAX'(hist_shift) ^ cfg_q.pattern) & len_mask(cfg_q.len)) == '0);

        cfg_d  = cfg_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;

        if (cfg_load) begin
            cfg_d.pattern = CFG_PAT_MAX'(cfg_pattern);
            cfg_d.len     = CFG_LEN_W'(cfg_len);
            cfg_d.overlap = cfg_overlap;
            fill_d        = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
            fill_d = (hit && !cfg_q.overlap) ? '0 : fill_inc;
            det_d  = hit;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q  <= CFG_RESET;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign detector_out = det_q;

    // The oldest history bit is shifted out before any compare can see it.
`ifdef SEQDET_MATCH_CNT_EN
    logic unused_bits;
    assign unused_bits = hist_q[PAT_W-1];

    seqdet_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (rst_n),
        .inc   (det_d),
        .count (match_count)
    );
`else
    // CNT_W only sizes the counter, which this build leaves out.
    logic unused_bits;
    assign unused_bits = hist_q[PAT_W-1] ^ (CNT_W != 0);
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param plus hand-written reset sequences.
// Latency: checks detector_out 1 ns after the accepting rising edge.
// Backpressure: exercises in_valid gaps and cfg_load with data present.
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             sequence_in = 1'b0;
    logic             in_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             detector_out;
`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_count;
`endif

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .detector_out (detector_out)
`ifdef SEQDET_MATCH_CNT_EN
        ,
        .match_count  (match_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             load;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic             ovl;
        logic             vld;
        logic             din;
        logic             exp_det;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                       input logic o, input logic v, input logic d, input logic e);
        vec_t t;
        t.load = ld; t.pat = p; t.len = l; t.ovl = o; t.vld = v; t.din = d; t.exp_det = e;
        vecs.push_back(t);
    endtask

    task automatic add_bit(input logic d, input logic e);
        add(1'b0, '0, '0, 1'b0, 1'b1, d, e);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Loads carry a valid '1' bit that the DUT must throw away.
    task automatic add_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        add(1'b1, p, l, o, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drive(input vec_t t);
        @(negedge clock);
        cfg_load    = t.load;
        cfg_pattern = t.pat;
        cfg_len     = t.len;
        cfg_overlap = t.ovl;
        in_valid    = t.vld;
        sequence_in = t.din;
        @(posedge clock);
        #1;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(vecs[i]);
            check($sformatf("vec%0d detector_out", i), 32'(detector_out), 32'(vecs[i].exp_det));
        end
    endtask

    task automatic send(input logic d, input logic e, input string name);
        vec_t t;
        t.load = 1'b0; t.pat = '0; t.len = '0; t.ovl = 1'b0; t.vld = 1'b1; t.din = d; t.exp_det = e;
        drive(t);
        check(name, 32'(detector_out), 32'(e));
    endtask

    task automatic quiet_inputs();
        in_valid = 1'b0;
        cfg_load = 1'b0;
        sequence_in = 1'b0;
    endtask

    task automatic wait_release();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    int a_end;
    int n_all;

    initial begin
        // Defaults, overlap on: 1011011 -> pulses after bits 4 and 7.
        add_bit(1, 0); add_bit(0, 0); add_bit(1, 0); add_bit(1, 1);
        add_bit(0, 0); add_bit(1, 0); add_bit(1, 1);
        a_end = vecs.size();
        // Non-overlapping 1011: 10110111011 -> pulses after bits 4 and 11 only.
        add_load(8'h0B, 4'd4, 1'b0);
        add_bit(1, 0); add_bit(0, 0); add_bit(1, 0); add_bit(1, 1);
        add_bit(0, 0); add_bit(1, 0); add_bit(1, 0); add_bit(1, 0);
        add_bit(0, 0); add_bit(1, 0); add_bit(1, 1);
        // Bit presented with cfg_load must not count: 0,1,1 alone is too short.
        add_load(8'h0B, 4'd4, 1'b1);
        add_bit(0, 0); add_bit(1, 0); add_bit(1, 0);
        // Sparse valid: three idle cycles between bits, one pulse after the fourth.
        add_load(8'h0B, 4'd4, 1'b1);
        add_bit(1, 0); add_idle(3); add_bit(0, 0); add_idle(3);
        add_bit(1, 0); add_idle(3); add_bit(1, 1); add_idle(3);
        // Length beyond PAT_W disables detection.
        add_load(8'h0B, 4'd9, 1'b1);
        add_bit(1, 0); add_bit(0, 0); add_bit(1, 0); add_bit(1, 0);
        // Length 1, overlapping: every '1' matches.
        add_load(8'h01, 4'd1, 1'b1);
        add_bit(1, 1); add_bit(1, 1); add_bit(0, 0); add_bit(1, 1);
        // Full-width pattern 11000011 matches once.
        add_load(8'hC3, 4'd8, 1'b1);
        add_bit(1, 0); add_bit(1, 0); add_bit(0, 0); add_bit(0, 0);
        add_bit(0, 0); add_bit(0, 0); add_bit(1, 0); add_bit(1, 1);
        // Length 0 disables detection.
        add_load(8'hC3, 4'd0, 1'b1);
        add_bit(1, 0); add_bit(1, 0); add_bit(0, 0); add_bit(0, 0);
        add_bit(0, 0); add_bit(0, 0); add_bit(1, 0); add_bit(1, 0);
        n_all = vecs.size();

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("reset detector_out", 32'(detector_out), 32'd0);
`ifdef SEQDET_MATCH_CNT_EN
        check("reset match_count", 32'(match_count), 32'd0);
`endif
        wait_release();

        run_range(0, a_end);
`ifdef SEQDET_MATCH_CNT_EN
        check("match_count after 1011011", 32'(match_count), 32'd2);
`endif
        run_range(a_end, n_all);
`ifdef SEQDET_MATCH_CNT_EN
        // Nine matches in total with a 2-bit counter: saturated, loads never cleared it.
        check("match_count saturated", 32'(match_count), 32'd3);
`endif

        // Reset restores the default config, and clears the output immediately.
        @(negedge clock);
        quiet_inputs();
        reset = 1'b0;
        #1;
`ifdef SEQDET_MATCH_CNT_EN
        check("match_count cleared by reset", 32'(match_count), 32'd0);
`endif
        repeat (2) @(negedge clock);
        wait_release();
        send(1, 0, "dflt bit1");
        send(0, 0, "dflt bit2");
        send(1, 0, "dflt bit3");
        send(1, 1, "dflt bit4 pulse");
        #2;
        reset = 1'b0;
        #1;
        check("async reset clears detector_out", 32'(detector_out), 32'd0);
        quiet_inputs();
        repeat (2) @(negedge clock);
        wait_release();

        // Partial match is lost across reset.
        send(1, 0, "pre-reset bit1");
        send(0, 0, "pre-reset bit2");
        send(1, 0, "pre-reset bit3");
        @(negedge clock);
        quiet_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        wait_release();
        send(1, 0, "post-reset bit1 no pulse");
        send(0, 0, "post-reset bit2");
        send(1, 0, "post-reset bit3");
        send(1, 1, "post-reset bit4 pulse");
        @(negedge clock);
        quiet_inputs();
        @(posedge clock);
        #1;
        check("pulse lasts one cycle", 32'(detector_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W: default 8; maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W: default 16; match counter width.
REQ-003 Parameter DEF_PATTERN: default 8'b0000_1011; pattern loaded at reset, right-aligned.
REQ-004 Parameter DEF_LEN: default 4; pattern length loaded at reset.
REQ-005 Derived LEN_W = $clog2(PAT_W+1).
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-008 sequence_in  in  1  serial data bit.
REQ-009 in_valid  in  1  sequence_in sampled only on edges where in_valid=1.
REQ-010 cfg_load  in  1  single-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
REQ-011 cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-012 cfg_len  in  LEN_W  active pattern length.
REQ-013 cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-014 detector_out  out  1  registered one-cycle match pulse.
REQ-015 match_count  out  CNT_W  saturating match count; present only when SEQDET_MATCH_CNT_EN is defined.

Function
REQ-016 History: PAT_W-bit shift register; on an accepted bit, shift left and insert sequence_in at bit 0.
REQ-017 Fill counter: counts accepted bits since the last clear; saturates at PAT_W.
REQ-018 Match condition, evaluated on the post-shift history: fill >= len and history[len-1:0] == pattern[len-1:0].
REQ-019 detector_out is 1 for exactly the cycle after the edge that accepted the final pattern bit; it is 0 otherwise, including on edges with in_valid=0.
REQ-020 Overlap=1: a match leaves history and fill unchanged (e.g. 1011 detected twice in 1011011).
REQ-021 Overlap=0: a match clears fill to 0 on the same edge, so the next match needs len fresh bits.
REQ-022 len == 0 or len > PAT_W: detection disabled; detector_out stays 0 while history still shifts.
REQ-023 cfg_load=1: latch the config, clear fill, and drive detector_out 0 on that edge; sequence_in on the same edge is discarded even when in_valid=1.
REQ-024 Config registers change only on cfg_load edges or reset.
REQ-025 Latency: exactly one clock from the accepting edge to detector_out; no combinational path from inputs to outputs.

Reset
REQ-026 While reset=0: history=0, fill=0, detector_out=0, match_count=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=1.
REQ-027 Reset asserted mid-sequence discards any partial match; after release a full len bits are needed.
REQ-028 Reset release is synchronised to clock inside the block before it reaches the state registers.

Configuration
REQ-029 Macro SEQDET_MATCH_CNT_EN defined: the match_count port exists.
REQ-030 With the macro: match_count increments on each edge that sets detector_out, saturates at all-ones, and cfg_load does not clear it.
REQ-031 Without the macro: the match_count port and the counter logic are absent; all other behaviour is identical.

Structure
REQ-032 Package seqdet_pkg holds the default constants (DEF_PATTERN, DEF_LEN, default PAT_W and CNT_W) and a config struct typedef (pattern, len, overlap).
REQ-033 Sub-module seqdet_match_cnt holds the saturating counter and is instantiated only under SEQDET_MATCH_CNT_EN.
REQ-034 Top level holds the config registers, history, fill counter, match compare and output register.

Verification
REQ-035 Defaults, overlap=1, stream 1,0,1,1,0,1,1 (in_valid=1 every cycle) -> detector_out pulses after bits 4 and 7; match_count=2.
REQ-036 Load pattern 1011, len 4, overlap=0; stream 1,0,1,1,0,1,1,1,0,1,1 -> pulses after bits 4 and 11 only.
REQ-037 Stream 1,0,1,1 with in_valid low for 3 cycles between every bit -> a single pulse, one cycle after the fourth accepted bit.
REQ-038 After 1,0,1 assert reset for 2 cycles, release, then send 1 -> no pulse; then 0,1,1 -> pulse.
REQ-039 Load pattern 8'b1100_0011, len 8; send the pattern; load len 0 and resend -> first pass pulses once, second pass never pulses.
REQ-040 CNT_W=2 with the macro defined, 5 matches -> match_count=3 (saturated); build without the macro -> compiles with no match_count port.
